fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   IF stage of the 5-stage RISC-V pipeline: owns the PC register and drives the instruction-memory word address.
//   Captures the returned instruction into the IF/ID pipeline register.
//   Handles hazard stalls, branch/jump redirects, IF/ID flushes and a global freeze with a deferred redirect.
// PARAMETERS
//   RESET_PC    32'h0000_0000  PC loaded on reset (byte address, word aligned)
//   IMEM_DEPTH  100            instruction memory size in words; fetches at or beyond it are invalid
//   NOP_INSTR   32'h0000_0013  bubble encoding (addi x0,x0,0)
// PORTS
//   clk              in   1   single clock, all state updates on rising edge
//   rst_n            in   1   synchronous reset, active low
//   stall            in   1   hazard-unit stall: hold PC and IF/ID
//   freeze           in   1   global pipeline freeze: hold all state, defer redirects
//   flush            in   1   load bubble into IF/ID
//   redirect         in   1   taken branch/jump resolved downstream
//   redirect_target  in   32  new fetch byte address
//   imem_addr        out  32  word index to instruction memory = {2'b00, pc[31:2]} (combinational)
//   imem_instr       in   32  instruction word from memory (combinational read)
//   pc               out  32  current fetch PC (byte address)
//   ifid_pc          out  32  IF/ID: PC of held instruction
//   ifid_instr       out  32  IF/ID: instruction
//   ifid_valid       out  1   IF/ID: 1 = real instruction, 0 = bubble
//   misalign         out  1   registered 1-cycle pulse: applied target had [1:0] != 0
// BEHAVIOUR
//   Reset (rst_n=0 at edge): pc=RESET_PC, ifid_pc=0, ifid_instr=NOP_INSTR, ifid_valid=0.
//   Reset also clears misalign, pending_valid, pending_target=0 and state=RUN. Reset overrides every other input.
//   State machine RUN / HOLD:
//     RUN, freeze=0: normal update, priority redirect > stall > sequential.
//     RUN, freeze=1: all regs hold. If redirect=1, latch pending_target and set pending_valid; go to HOLD.
//     HOLD, freeze=1: hold. A new redirect overwrites pending_target (last one wins).
//     HOLD, freeze=0: apply pending redirect as if redirect=1 this cycle, clear pending_valid, go to RUN.
//       A live redirect in the same cycle beats the pending one.
//   Redirect applied: pc <= {target[31:2],2'b00}. IF/ID <= bubble (ifid_instr=NOP_INSTR, valid=0).
//     misalign <= |target[1:0]. Redirect overrides stall.
//   Stall (no redirect): pc and IF/ID hold. If flush=1, IF/ID <= bubble while pc still holds.
//   Sequential: pc <= pc + 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
//     IF/ID <= {pc, imem_instr, 1}, or a bubble if flush=1.
//   Out of range: if pc[31:2] >= IMEM_DEPTH, IF/ID loads ifid_pc=pc, instr=NOP_INSTR, valid=0.
//     pc keeps advancing.
//   misalign is 0 on every cycle without an applied redirect.
//   Latency: instruction at pc appears on ifid_* one edge later.
// CONFIGURATION
//   FETCH_PERF_EN defined: adds outputs perf_fetched[31:0] and perf_bubbles[31:0].
//     Both reset to 0, wrap at 2^32, frozen while freeze=1.
//     perf_fetched increments per edge loading ifid_valid=1.
//     perf_bubbles increments per edge loading ifid_valid=0 (stall-hold edges excluded).
//   FETCH_PERF_EN undefined: ports and counters are absent; behaviour otherwise identical.
// TESTING
//   1 Reset: rst_n=0 two cycles, then 1, memory word0=32'h00500093
//     -> pc=0, ifid_valid=0. After 1 edge: ifid_pc=0, ifid_instr=32'h00500093, valid=1, pc=4.
//   2 Stall: at pc=8 assert stall 2 cycles -> pc stays 8, ifid unchanged.
//     Stall+flush -> ifid_valid=0, pc=8.
//   3 Redirect: pc=12, redirect=1, target=32'h40 with stall=1
//     -> pc=32'h40, ifid bubble, misalign=0. Target 32'h42 -> pc=32'h40, misalign=1 for one cycle.
//   4 Freeze: freeze=1 for 3 cycles with redirects to 32'h20 then 32'h30
//     -> all regs hold. First cycle after freeze=0: pc=32'h30, ifid bubble.
//   5 Range/wrap: RESET_PC=4*(IMEM_DEPTH-1) -> first fetch valid, next (word 100) valid=0 with NOP.
//     RESET_PC=32'hFFFF_FFFC -> pc wraps to 0.
//   6 FETCH_PERF_EN: 5 sequential fetches, 1 flush, 2 stall cycles
//     -> perf_fetched=5, perf_bubbles=1 (plus reset bubble rules as specified).

Source files
------------

// File: rtl/fetch_stage.sv
// IF stage: PC register, imem word addressing and the IF/ID pipeline register.
// Optional build macro FETCH_PERF_EN adds fetch/bubble performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 100,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        freeze,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        misalign
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t      state, state_nx;
  logic        pend_v, pend_v_nx;
  logic [31:0] pend_t, pend_t_nx;
  logic        apply;
  logic [31:0] tgt;
  logic        oob;

  logic [31:0] pc_nx, ipc_nx, ins_nx;
  logic        v_nx, mis_nx;

  assign imem_addr = {2'b00, pc[31:2]};
  assign oob = ({2'b00, pc[31:2]} >= 32'(IMEM_DEPTH));

  // Freeze FSM: defer redirects while frozen, replay one on release
  always_comb begin
    state_nx  = state;
    pend_v_nx = pend_v;
    pend_t_nx = pend_t;
    apply     = 1'b0;
    tgt       = redirect_target;
    unique case (state)
      RUN: begin
        if (freeze) begin
          if (redirect) begin
            pend_t_nx = redirect_target;
            pend_v_nx = 1'b1;
            state_nx  = HOLD;
          end
        end else begin
          apply = redirect;
        end
      end
      HOLD: begin
        if (freeze) begin
          if (redirect) pend_t_nx = redirect_target;
        end else begin
          apply     = redirect | pend_v;
          tgt       = redirect ? redirect_target : pend_t;
          pend_v_nx = 1'b0;
          state_nx  = RUN;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  // Datapath next values: redirect > stall > sequential
  always_comb begin
    pc_nx  = pc;
    ipc_nx = ifid_pc;
    ins_nx = ifid_instr;
    v_nx   = ifid_valid;
    mis_nx = 1'b0;
    if (!freeze) begin
      priority case (1'b1)
        apply: begin
          pc_nx  = {tgt[31:2], 2'b00};
          ins_nx = NOP_INSTR;
          v_nx   = 1'b0;
          mis_nx = |tgt[1:0];
        end
        stall: begin
          if (flush) begin
            ins_nx = NOP_INSTR;
            v_nx   = 1'b0;
          end
        end
        default: begin
          pc_nx = pc + 32'd4;
          if (flush) begin
            ins_nx = NOP_INSTR;
            v_nx   = 1'b0;
          end else if (oob) begin
            ipc_nx = pc;
            ins_nx = NOP_INSTR;
            v_nx   = 1'b0;
          end else begin
            ipc_nx = pc;
            ins_nx = imem_instr;
            v_nx   = 1'b1;
          end
        end
      endcase
    end
  end

  // State and pipeline registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      pend_v     <= 1'b0;
      pend_t     <= 32'h0;
      pc         <= RESET_PC;
      ifid_pc    <= 32'h0;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      state      <= state_nx;
      pend_v     <= pend_v_nx;
      pend_t     <= pend_t_nx;
      pc         <= pc_nx;
      ifid_pc    <= ipc_nx;
      ifid_instr <= ins_nx;
      ifid_valid <= v_nx;
      misalign   <= mis_nx;
    end
  end

`ifdef FETCH_PERF_EN
  logic ld;
  assign ld = !freeze && (apply || !stall || flush);

  // Count IF/ID loads by kind; stall-hold and frozen edges are not loads
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched <= 32'h0;
      perf_bubbles <= 32'h0;
    end else if (ld) begin
      if (v_nx) perf_fetched <= perf_fetched + 32'd1;
      else      perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed vectors queue expectations,
// a negedge monitor pops and compares them cycle by cycle.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        freeze = 1'b0;
  logic        flush = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic [31:0] imem_addr, imem_instr, pc, ifid_pc, ifid_instr;
  logic        ifid_valid, misalign;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_bubbles;
`endif

  logic [31:0] mem [0:99];

  always #5 clk = ~clk;

  assign imem_instr = (imem_addr < 32'd100) ? mem[imem_addr[6:0]]
                                            : 32'hDEAD_BEEF;

  fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .freeze          (freeze),
    .flush           (flush),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .pc              (pc),
    .ifid_pc         (ifid_pc),
    .ifid_instr      (ifid_instr),
    .ifid_valid      (ifid_valid),
    .misalign        (misalign)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_bubbles    (perf_bubbles)
`endif
  );

  typedef struct {
    int          cyc;
    string       name;
    bit          perf;
    logic [31:0] pc;
    logic [31:0] ipc;
    logic [31:0] ins;
    logic        v;
    logic        mis;
    bit          cipc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // Monitor: compare every expectation due on this cycle
  always @(negedge clk) begin : mon
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: stale entry cyc %0d now %0d", e.name, e.cyc, cyc);
      end else if (e.perf) begin
`ifdef FETCH_PERF_EN
        chk({e.name, ".fetched"}, perf_fetched, e.pc);
        chk({e.name, ".bubbles"}, perf_bubbles, e.ipc);
`endif
      end else begin
        chk({e.name, ".pc"}, pc, e.pc);
        chk({e.name, ".instr"}, ifid_instr, e.ins);
        chk({e.name, ".valid"}, {31'h0, ifid_valid}, {31'h0, e.v});
        chk({e.name, ".misalign"}, {31'h0, misalign}, {31'h0, e.mis});
        if (e.cipc) chk({e.name, ".ifid_pc"}, ifid_pc, e.ipc);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string n, input logic s, input logic fz,
                      input logic fl, input logic rd, input logic [31:0] t,
                      input logic [31:0] epc, input logic [31:0] eipc,
                      input logic [31:0] eins, input logic ev,
                      input logic emis, input bit cipc);
    exp_t e;
    stall = s;
    freeze = fz;
    flush = fl;
    redirect = rd;
    redirect_target = t;
    e.cyc = cyc + 1;
    e.name = n;
    e.perf = 1'b0;
    e.pc = epc;
    e.ipc = eipc;
    e.ins = eins;
    e.v = ev;
    e.mis = emis;
    e.cipc = cipc;
    q.push_back(e);
    tick();
  endtask

  task automatic push_perf(input string n, input logic [31:0] f,
                           input logic [31:0] b);
    exp_t e;
    e.cyc = cyc + 1;
    e.name = n;
    e.perf = 1'b1;
    e.pc = f;
    e.ipc = b;
    e.ins = 32'h0;
    e.v = 1'b0;
    e.mis = 1'b0;
    e.cipc = 1'b0;
    q.push_back(e);
  endtask

  initial begin
    for (int i = 0; i < 100; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[0] = 32'h0050_0093;

    rst_n = 1'b0;
    step("rst0", 0, 0, 0, 0, 0, 0, 0, NOP, 0, 0, 1);
    step("rst1", 0, 0, 0, 0, 0, 0, 0, NOP, 0, 0, 1);
    rst_n = 1'b1;
    step("first", 0, 0, 0, 0, 0, 4, 0, 32'h0050_0093, 1, 0, 1);
    step("seq1", 0, 0, 0, 0, 0, 8, 4, 32'hA000_0001, 1, 0, 1);
    step("stall0", 1, 0, 0, 0, 0, 8, 4, 32'hA000_0001, 1, 0, 1);
    step("stall1", 1, 0, 0, 0, 0, 8, 4, 32'hA000_0001, 1, 0, 1);
    step("stflush", 1, 0, 1, 0, 0, 8, 0, NOP, 0, 0, 0);
    step("seq2", 0, 0, 0, 0, 0, 12, 8, 32'hA000_0002, 1, 0, 1);
    step("redir40", 1, 0, 0, 1, 32'h40, 32'h40, 0, NOP, 0, 0, 0);
    step("seq40", 0, 0, 0, 0, 0, 32'h44, 32'h40, 32'hA000_0010, 1, 0, 1);
    step("redir42", 0, 0, 0, 1, 32'h42, 32'h40, 0, NOP, 0, 1, 0);
    step("mis_clr", 0, 0, 0, 0, 0, 32'h44, 32'h40, 32'hA000_0010, 1, 0, 1);
    step("frz0", 0, 1, 0, 1, 32'h20, 32'h44, 32'h40, 32'hA000_0010, 1, 0, 1);
    step("frz1", 0, 1, 0, 0, 0, 32'h44, 32'h40, 32'hA000_0010, 1, 0, 1);
    step("frz2", 0, 1, 0, 1, 32'h30, 32'h44, 32'h40, 32'hA000_0010, 1, 0, 1);
    step("unfrz", 0, 0, 0, 0, 0, 32'h30, 0, NOP, 0, 0, 0);
    step("seq30", 0, 0, 0, 0, 0, 32'h34, 32'h30, 32'hA000_000C, 1, 0, 1);
    step("frz3", 0, 1, 0, 1, 32'h50, 32'h34, 32'h30, 32'hA000_000C, 1, 0, 1);
    step("livewin", 0, 0, 0, 1, 32'h62, 32'h60, 0, NOP, 0, 1, 0);
    step("seq60", 0, 0, 0, 0, 0, 32'h64, 32'h60, 32'hA000_0018, 1, 0, 1);
    step("redirtop", 0, 0, 0, 1, 32'h18C, 32'h18C, 0, NOP, 0, 0, 0);
    step("lastword", 0, 0, 0, 0, 0, 32'h190, 32'h18C, 32'hA000_0063, 1, 0, 1);
    step("oob", 0, 0, 0, 0, 0, 32'h194, 32'h190, NOP, 0, 0, 1);
    step("redirwrap", 0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, NOP, 0, 0, 0);
    step("wrap", 0, 0, 0, 0, 0, 32'h0, 32'hFFFF_FFFC, NOP, 0, 0, 1);
    step("postwrap", 0, 0, 0, 0, 0, 32'h4, 32'h0, 32'h0050_0093, 1, 0, 1);
    step("seqflush", 0, 0, 1, 0, 0, 32'h8, 0, NOP, 0, 0, 0);

`ifdef FETCH_PERF_EN
    rst_n = 1'b0;
    push_perf("perf_rst", 0, 0);
    step("prst", 0, 0, 0, 0, 0, 0, 0, NOP, 0, 0, 1);
    rst_n = 1'b1;
    step("pf0", 0, 0, 0, 0, 0, 4, 0, 32'h0050_0093, 1, 0, 1);
    step("pf1", 0, 0, 0, 0, 0, 8, 4, 32'hA000_0001, 1, 0, 1);
    step("pf2", 0, 0, 0, 0, 0, 12, 8, 32'hA000_0002, 1, 0, 1);
    step("pf3", 0, 0, 0, 0, 0, 16, 12, 32'hA000_0003, 1, 0, 1);
    step("pf4", 0, 0, 0, 0, 0, 20, 16, 32'hA000_0004, 1, 0, 1);
    step("ps0", 1, 0, 0, 0, 0, 20, 16, 32'hA000_0004, 1, 0, 1);
    step("ps1", 1, 0, 0, 0, 0, 20, 16, 32'hA000_0004, 1, 0, 1);
    push_perf("perf_end", 5, 1);
    step("pfl", 0, 0, 1, 0, 0, 24, 0, NOP, 0, 0, 0);
`endif

    stall = 1'b0;
    freeze = 1'b0;
    flush = 1'b0;
    redirect = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
